gl_cmd_writer: RTL and testbench

Producer end of the GL command buffer consumed by `gl_fetch`. Accepts a stream of command words from the host-side command builder, writes them to command memory at the variable-length strides `gl_fetch` expects, and publishes a committed tail pointer. Wraps whole commands back to `text_start` and never overwrites commands `gl_fetch` has not yet fetched.

---
 rtl/gl_cmd_writer_pkg.sv | 31 +++
 rtl/gl_cmd_len.sv | 25 ++
 rtl/gl_cmd_writer.sv | 132 +++++++++++++
 tb/tb_gl_cmd_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gl_cmd_writer_pkg.sv
// Shared opcode/length table and state encoding for the GL command writer.
// gl_fetch imports the same constants so both ends agree on command strides.
package gl_cmd_writer_pkg;

  localparam logic [7:0] OP_VERTEX     = 8'h01;
  localparam logic [7:0] OP_COLOR      = 8'h02;
  localparam logic [7:0] OP_MULTMATRIX = 8'h03;
  localparam logic [7:0] OP_LOADMATRIX = 8'h04;
  localparam logic [7:0] OP_ROTATE     = 8'h05;
  localparam logic [7:0] OP_SCALE      = 8'h06;
  localparam logic [7:0] OP_TRANSLATE  = 8'h07;
  localparam logic [7:0] OP_VIEWPORT   = 8'h08;
  localparam logic [7:0] OP_FRUSTUM    = 8'h09;

  localparam logic [4:0] GL_LEN_VERTEX   = 5'd4;
  localparam logic [4:0] GL_LEN_COLOR    = 5'd4;
  localparam logic [4:0] GL_LEN_MATRIX   = 5'd17;
  localparam logic [4:0] GL_LEN_VIEWPORT = 5'd5;
  localparam logic [4:0] GL_LEN_FRUSTUM  = 5'd7;
  localparam logic [4:0] GL_LEN_DEFAULT  = 5'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPER = 1'b1
  } wr_state_t;

  function automatic logic [6:0] cmd_bytes(input logic [4:0] len);
    return {len, 2'b00};
  endfunction

endpackage

// File: rtl/gl_cmd_len.sv
// Combinational opcode -> command length (words, header included) decoder.
module gl_cmd_len
  import gl_cmd_writer_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [4:0] o_len
);

  always_comb begin
    o_len = GL_LEN_DEFAULT;
    case (i_opcode)
      OP_VERTEX:     o_len = GL_LEN_VERTEX;
      OP_COLOR:      o_len = GL_LEN_COLOR;
      OP_MULTMATRIX,
      OP_LOADMATRIX,
      OP_ROTATE,
      OP_SCALE,
      OP_TRANSLATE:  o_len = GL_LEN_MATRIX;
      OP_VIEWPORT:   o_len = GL_LEN_VIEWPORT;
      OP_FRUSTUM:    o_len = GL_LEN_FRUSTUM;
      default:       o_len = GL_LEN_DEFAULT;
    endcase
  end

endmodule

// File: rtl/gl_cmd_writer.sv
// Producer side of the GL command ring: places whole commands, wraps them to
// text_start when they would cross text_end, and never overruns gl_fetch.
module gl_cmd_writer
  import gl_cmd_writer_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TEXT_START = 32'hA000_0000,
  parameter logic [WIDTH-1:0] TEXT_END   = 32'hA001_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] rd_addr,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic             mem_stall,
  output logic [WIDTH-1:0] tail_addr,
  output logic             busy,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] WORD_BYTES = WIDTH'(4);

  wr_state_t        r_state;
  logic [4:0]       r_remaining;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_cmd_end;
  logic             r_wr_en;
  logic [WIDTH-1:0] r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;
  logic             r_wr_last;
  logic [WIDTH-1:0] r_tail;
  logic             r_busy;
  logic             r_wrap_pulse;

  logic [4:0]       w_len;
  logic [WIDTH-1:0] w_bytes;
  logic [WIDTH-1:0] w_p_end;
  logic [WIDTH-1:0] w_wrap_end;
  logic             w_wrap;
  logic [WIDTH-1:0] w_start;
  logic [WIDTH-1:0] w_cmd_end;
  logic             w_fits;
  logic             w_can_issue;
  logic             w_accept;
  logic             w_retire;

  gl_cmd_len u_len (
    .i_opcode (cmd_data[7:0]),
    .o_len    (w_len)
  );

  assign w_bytes    = {{(WIDTH-7){1'b0}}, cmd_bytes(w_len)};
  assign w_p_end    = r_p + w_bytes;
  assign w_wrap_end = TEXT_START + w_bytes;
  assign w_wrap     = w_p_end > TEXT_END;
  assign w_start    = w_wrap ? TEXT_START : r_p;
  assign w_cmd_end  = w_wrap ? w_wrap_end : w_p_end;

  // Strict '<' leaves one word free so rd_addr == tail_addr always means empty.
  assign w_fits = w_wrap ? ((rd_addr <= r_p) && (w_wrap_end < rd_addr))
                         : ((rd_addr <= r_p) || (w_p_end < rd_addr));

  assign w_can_issue = ~r_wr_en | ~mem_stall;
  assign cmd_ready   = w_can_issue & ((r_state == ST_OPER) | w_fits);
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_retire    = r_wr_en & ~mem_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= 5'd0;
      r_p          <= TEXT_START;
      r_cmd_end    <= TEXT_START;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= TEXT_START;
      r_wr_data    <= '0;
      r_wr_last    <= 1'b0;
      r_tail       <= TEXT_START;
      r_busy       <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_wrap_pulse <= 1'b0;
      // r_cmd_end still belongs to the retiring command even if a new header lands now.
      if (w_retire && r_wr_last) begin
        r_tail <= r_cmd_end;
      end
      if (w_accept) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= cmd_data;
        if (r_state == ST_IDLE) begin
          r_wr_addr    <= w_start;
          r_p          <= w_start + WORD_BYTES;
          r_cmd_end    <= w_cmd_end;
          r_wrap_pulse <= w_wrap;
          if (w_len > 5'd1) begin
            r_state     <= ST_OPER;
            r_remaining <= w_len - 5'd1;
            r_busy      <= 1'b1;
            r_wr_last   <= 1'b0;
          end else begin
            r_wr_last   <= 1'b1;
          end
        end else begin
          r_wr_addr   <= r_p;
          r_p         <= r_p + WORD_BYTES;
          r_remaining <= r_remaining - 5'd1;
          if (r_remaining == 5'd1) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_wr_last <= 1'b1;
          end else begin
            r_wr_last <= 1'b0;
          end
        end
      end else if (w_retire) begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign tail_addr   = r_tail;
  assign busy        = r_busy;
  assign wrap_pulse  = r_wrap_pulse;

endmodule

// File: tb/tb_gl_cmd_writer.sv
// Self-checking bench for gl_cmd_writer: a vector table, directed corner
// sequences and a randomized run against a queue-based ring model.
module tb_gl_cmd_writer;

  localparam logic [31:0] T_START = 32'hA000_0000;
  localparam logic [31:0] T_END   = 32'hA000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic [31:0] rd_addr = T_START;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_stall = 1'b0;
  logic [31:0] tail_addr;
  logic        busy;
  logic        wrap_pulse;

  always #5 clk = ~clk;

  gl_cmd_writer #(
    .WIDTH      (32),
    .TEXT_START (T_START),
    .TEXT_END   (T_END)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .rd_addr     (rd_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_stall   (mem_stall),
    .tail_addr   (tail_addr),
    .busy        (busy),
    .wrap_pulse  (wrap_pulse)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
    logic [31:0] tail;
  } wr_t;

  // Reference model: expected memory writes in issue order plus ring pointers.
  wr_t         m_q[$];
  logic [31:0] m_p = T_START;
  logic [31:0] m_tail = T_START;
  logic [31:0] m_end = T_START;
  int          m_rem = 0;
  bit          m_wrap = 1'b0;
  int          n_retire = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic int op_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h02:                      return 4;
      8'h03, 8'h04, 8'h05, 8'h06, 8'h07: return 17;
      8'h08:                             return 5;
      8'h09:                             return 7;
      default:                           return 1;
    endcase
  endfunction

  // Bytes gl_fetch has not consumed yet: circular range [rd, p).
  function automatic bit unfetched(input logic [31:0] a, input logic [31:0] rd, input logic [31:0] p);
    if (rd <= p) return (a >= rd) && (a < p);
    return (a >= rd) || (a < p);
  endfunction

  // A command fits if none of its words land on unfetched data and the new
  // tail does not collide with the consumer (which would read as empty).
  function automatic bit model_fits(input logic [31:0] p, input logic [31:0] rd, input int len,
                                    output logic [31:0] s, output bit wrap);
    wrap = (p + 32'(4 * len)) > T_END;
    s    = wrap ? T_START : p;
    for (int k = 0; k < len; k++) begin
      if (unfetched(s + 32'(4 * k), rd, p)) return 1'b0;
    end
    return (s + 32'(4 * len)) != rd;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input logic [31:0] d, input logic [31:0] rd, input bit st,
                      output bit acc, output bit rdy);
    int          len;
    logic [31:0] s;
    bit          wrap;
    bit          fits;
    bit          exp_ready;
    bit          retire;
    wr_t         w;
    len = 1;
    s = m_p;
    wrap = 1'b0;
    cmd_valid = v;
    cmd_data  = d;
    rd_addr   = rd;
    mem_stall = st;
    #1;
    chk1("mem_wr_en", mem_wr_en, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("mem_wr_addr", mem_wr_addr, m_q[0].addr);
      chk("mem_wr_data", mem_wr_data, m_q[0].data);
    end
    chk("tail_addr", tail_addr, m_tail);
    chk1("busy", busy, m_rem > 0);
    chk1("wrap_pulse", wrap_pulse, m_wrap);
    if (m_rem == 0) begin
      len  = op_len(d[7:0]);
      fits = model_fits(m_p, rd, len, s, wrap);
    end else begin
      fits = 1'b1;
    end
    exp_ready = ((m_q.size() == 0) || !st) && fits;
    rdy = cmd_ready;
    chk1("cmd_ready", cmd_ready, exp_ready);
    acc    = v && exp_ready;
    retire = (m_q.size() > 0) && !st;
    @(posedge clk);
    if (retire) begin
      w = m_q.pop_front();
      n_retire++;
      if (w.last) m_tail = w.tail;
    end
    m_wrap = 1'b0;
    if (acc) begin
      if (m_rem == 0) begin
        m_end = s + 32'(4 * len);
        m_q.push_back('{addr: s, data: d, last: (len == 1), tail: m_end});
        m_p    = s + 32'd4;
        m_rem  = len - 1;
        m_wrap = wrap;
        $display("cmd op=%02h len=%0d start=%h wrap=%0d", d[7:0], len, s, wrap);
      end else begin
        m_rem--;
        m_q.push_back('{addr: m_p, data: d, last: (m_rem == 0), tail: m_end});
        m_p = m_p + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    mem_stall = 1'b0;
    rd_addr   = T_START;
    reset     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_q.delete();
    m_p    = T_START;
    m_tail = T_START;
    m_end  = T_START;
    m_rem  = 0;
    m_wrap = 1'b0;
    reset  = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] rd, input int stall_pct);
    bit acc;
    bit rdy;
    int n;
    n = 0;
    do begin
      step(1'b1, d, rd, $urandom_range(0, 99) < stall_pct, acc, rdy);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] rd, input int stall_pct);
    logic [31:0] r;
    r = $urandom;
    send({r[31:8], op}, rd, stall_pct);
    for (int k = 1; k < op_len(op); k++) send($urandom, rd, stall_pct);
  endtask

  task automatic drain(input logic [31:0] rd);
    bit acc;
    bit rdy;
    int n;
    n = 0;
    while (m_q.size() > 0 && n < 20) begin
      step(1'b0, 32'd0, rd, 1'b0, acc, rdy);
      n++;
    end
    step(1'b0, 32'd0, rd, 1'b0, acc, rdy);
  endtask

  typedef struct {
    bit          valid;
    logic [31:0] data;
    logic [31:0] rd;
    bit          stall;
    bit          exp_ready;
    bit          exp_wr_en;
    logic [31:0] exp_addr;
    logic [31:0] exp_tail;
    bit          exp_busy;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    bit          acc;
    bit          rdy;
    bit          held;
    bit          v;
    logic [31:0] d;
    logic [31:0] rd;
    logic [31:0] r;
    logic [7:0]  ops[10];
    int          idx;

    vecs[0] = '{1'b1, 32'h0000_0001, T_START, 1'b0, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000, 1'b1};
    vecs[1] = '{1'b1, 32'h1111_1111, T_START, 1'b0, 1'b1, 1'b1, 32'hA000_0004, 32'hA000_0000, 1'b1};
    vecs[2] = '{1'b1, 32'h2222_2222, T_START, 1'b0, 1'b1, 1'b1, 32'hA000_0008, 32'hA000_0000, 1'b1};
    vecs[3] = '{1'b1, 32'h3333_3333, T_START, 1'b0, 1'b1, 1'b1, 32'hA000_000C, 32'hA000_0000, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0000, T_START, 1'b0, 1'b1, 1'b0, 32'h0,         32'hA000_0010, 1'b0};
    vecs[5] = '{1'b1, 32'h5A5A_5AFF, T_START, 1'b0, 1'b1, 1'b1, 32'hA000_0010, 32'hA000_0010, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0000, T_START, 1'b0, 1'b1, 1'b0, 32'h0,         32'hA000_0014, 1'b0};
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hFF};

    // Reset values.
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_tail", tail_addr, T_START);
    chk1("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_wr_addr", mem_wr_addr, T_START);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wrap", wrap_pulse, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b1);

    // Vertex burst followed by a single-word unknown opcode.
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].valid, vecs[i].data, vecs[i].rd, vecs[i].stall, acc, rdy);
      chk1("tbl_ready", rdy, vecs[i].exp_ready);
      chk1("tbl_wr_en", mem_wr_en, vecs[i].exp_wr_en);
      if (vecs[i].exp_wr_en) chk("tbl_wr_addr", mem_wr_addr, vecs[i].exp_addr);
      chk("tbl_tail", tail_addr, vecs[i].exp_tail);
      chk1("tbl_busy", busy, vecs[i].exp_busy);
    end

    // Loadmatrix with a three-cycle stall on the second word.
    do_reset();
    n_retire = 0;
    send(32'h0000_0004, T_START, 0);
    send(32'hCAFE_0001, T_START, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hCAFE_0002, T_START, 1'b1, acc, rdy);
      chk1("stall_ready", rdy, 1'b0);
      chk1("stall_wr_en", mem_wr_en, 1'b1);
      chk("stall_addr", mem_wr_addr, 32'hA000_0004);
    end
    for (int k = 2; k < 17; k++) send(32'hCAFE_0000 + 32'(k), T_START, 0);
    drain(T_START);
    chk("lm_writes", 32'(n_retire), 32'd17);
    chk("lm_tail", tail_addr, T_START + 32'h44);

    // Fill to A00000F0, then a frustum must wrap to the ring base.
    do_reset();
    for (int i = 0; i < 15; i++) send_cmd(8'h01, m_p, 0);
    drain(m_p);
    chk("fill_tail", tail_addr, 32'hA000_00F0);
    send(32'h0000_0009, 32'hA000_00F0, 0);
    chk1("wrap_pulse_hi", wrap_pulse, 1'b1);
    chk("wrap_hdr_addr", mem_wr_addr, T_START);
    send(32'h7777_0001, 32'hA000_00F0, 0);
    chk1("wrap_pulse_lo", wrap_pulse, 1'b0);
    for (int k = 2; k < 7; k++) send(32'h7777_0000 + 32'(k), 32'hA000_00F0, 0);
    drain(32'hA000_00F0);
    chk("wrap_tail", tail_addr, 32'hA000_001C);

    // Space check: rd_addr one word too close blocks the header.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h0000_0001, 32'hA000_0010, 1'b0, acc, rdy);
      chk1("full_ready", rdy, 1'b0);
    end
    step(1'b1, 32'h0000_0001, 32'hA000_0014, 1'b0, acc, rdy);
    chk1("space_ready", rdy, 1'b1);
    chk("space_hdr_addr", mem_wr_addr, T_START);
    for (int k = 1; k < 4; k++) send(32'h4444_0000 + 32'(k), 32'hA000_0014, 0);
    drain(32'hA000_0014);
    chk("space_tail", tail_addr, 32'hA000_0010);

    // Reset in the middle of a rotate discards it.
    do_reset();
    send(32'h0000_0005, T_START, 0);
    send(32'h5555_0001, T_START, 0);
    send(32'h5555_0002, T_START, 0);
    chk1("mid_busy", busy, 1'b1);
    do_reset();
    #1;
    chk("mid_rst_tail", tail_addr, T_START);
    chk1("mid_rst_wr_en", mem_wr_en, 1'b0);
    chk("mid_rst_wr_addr", mem_wr_addr, T_START);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", cmd_ready, 1'b1);
    send(32'h0000_0001, T_START, 0);
    chk("mid_next_hdr", mem_wr_addr, T_START);
    for (int k = 1; k < 4; k++) send(32'h6666_0000 + 32'(k), T_START, 0);
    drain(T_START);

    // Randomized traffic with stalls and a moving consumer pointer.
    do_reset();
    held = 1'b0;
    v = 1'b0;
    d = '0;
    rd = T_START;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!held) begin
        v = $urandom_range(0, 9) < 7;
        if (m_rem == 0) begin
          idx = $urandom_range(0, 10);
          r = $urandom;
          d = {r[31:8], (idx == 10) ? r[7:0] : ops[idx]};
        end else begin
          d = $urandom;
        end
      end
      if ($urandom_range(0, 4) == 0) rd = T_START + 32'(4 * $urandom_range(0, 63));
      step(v, d, rd, $urandom_range(0, 3) == 0, acc, rdy);
      held = v && !acc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
